// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  // Fetch sequencer states: Boot after reset, Fetch with a live request,
  // Discard while waiting out an abandoned request, Hold while decode is stalled.
  typedef enum logic [1:0] {
    Boot,
    Fetch,
    Discard,
    Hold
  } fetch_state_t;

  // addi x0, x0, 0 -- the canonical RISC-V bubble instruction.
  localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with the IF/ID pipeline register. Owns the fetch PC,
// runs the request/ack handshake with instruction memory, throws away fetches
// that were overtaken by a redirect, and parks one instruction while decode stalls.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   DATA_SIZE = 64,
  parameter logic [DATA_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_if,
  input  logic                 stall_id,
  input  logic                 flush_id,
  input  logic                 redirect,
  input  logic [DATA_SIZE-1:0] new_pc,
  output logic                 inst_mem_en,
  output logic [DATA_SIZE-1:0] inst_mem_addr,
  input  logic                 inst_mem_ack,
  input  logic [31:0]          inst_mem_rd_dat,
  output logic [31:0]          inst_id,
  output logic [DATA_SIZE-1:0] pc_id,
  output logic                 valid_id
);

  localparam logic [DATA_SIZE-1:0] PC_STEP = DATA_SIZE'(4);

  fetch_state_t         state_q, state_d;
  logic [DATA_SIZE-1:0] req_addr_q, req_addr_d;
  logic [DATA_SIZE-1:0] pending_pc_q, pending_pc_d;
  logic [31:0]          buf_inst_q;
  logic [DATA_SIZE-1:0] buf_pc_q;
  logic                 buf_capture;
  logic                 id_load;
  logic [31:0]          load_inst;
  logic [DATA_SIZE-1:0] load_pc;
  logic                 stall;

  assign stall         = stall_if | stall_id;
  assign inst_mem_addr = req_addr_q;

  // Next-state, next-address and IF/ID load source for the fetch sequencer.
  // The buffer is only meaningful in Hold, so leaving Hold invalidates it.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    pending_pc_d = pending_pc_q;
    buf_capture  = 1'b0;
    id_load      = 1'b0;
    load_inst    = inst_mem_rd_dat;
    load_pc      = req_addr_q;
    inst_mem_en  = 1'b0;
    unique case (state_q)
      Boot: begin
        state_d    = Fetch;
        req_addr_d = redirect ? new_pc : RESET_PC;
      end
      Fetch: begin
        inst_mem_en = 1'b1;
        if (inst_mem_ack) begin
          if (redirect) begin
            req_addr_d = new_pc;
          end else if (!stall) begin
            id_load    = 1'b1;
            req_addr_d = req_addr_q + PC_STEP;
          end else begin
            buf_capture = 1'b1;
            state_d     = Hold;
          end
        end else if (redirect) begin
          pending_pc_d = new_pc;
          state_d      = Discard;
        end
      end
      Discard: begin
        inst_mem_en = 1'b1;
        if (inst_mem_ack) begin
          req_addr_d = redirect ? new_pc : pending_pc_q;
          state_d    = Fetch;
        end else if (redirect) begin
          pending_pc_d = new_pc;
        end
      end
      Hold: begin
        if (redirect) begin
          req_addr_d = new_pc;
          state_d    = Fetch;
        end else if (!stall) begin
          id_load    = 1'b1;
          load_inst  = buf_inst_q;
          load_pc    = buf_pc_q;
          req_addr_d = buf_pc_q + PC_STEP;
          state_d    = Fetch;
        end
      end
      default: state_d = Boot;
    endcase
  end

  // Sequencer state, request address and redirect target waiting on a stale ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= Boot;
      req_addr_q   <= RESET_PC;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  // One-entry buffer that parks a returned instruction while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_inst_q <= '0;
      buf_pc_q   <= '0;
    end else if (buf_capture) begin
      buf_inst_q <= inst_mem_rd_dat;
      buf_pc_q   <= req_addr_q;
    end
  end

  // IF/ID register: flush beats stall beats load; no load source means a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_id  <= NOP;
      pc_id    <= '0;
      valid_id <= 1'b0;
    end else if (flush_id) begin
      inst_id  <= NOP;
      valid_id <= 1'b0;
    end else if (stall_id) begin
      inst_id  <= inst_id;
    end else if (id_load) begin
      inst_id  <= load_inst;
      pc_id    <= load_pc;
      valid_id <= 1'b1;
    end else begin
      inst_id  <= NOP;
      valid_id <= 1'b0;
    end
  end

  // Memory may only acknowledge a request that is actually being made.
  ack_only_while_requesting: assert property (
    @(posedge clk) disable iff (!rst_n) inst_mem_ack |-> inst_mem_en
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against a program-order model of the instruction stream reaching decode.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DATA_SIZE = 64;
  localparam logic [63:0] RESET_PC  = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if, stall_id, flush_id, redirect;
  logic [63:0] new_pc;
  logic        inst_mem_en;
  logic [63:0] inst_mem_addr;
  logic        inst_mem_ack;
  logic [31:0] inst_mem_rd_dat;
  logic [31:0] inst_id;
  logic [63:0] pc_id;
  logic        valid_id;

  int errors     = 0;
  int checks     = 0;
  int deliveries = 0;
  int idle_cycles = 0;

  logic [63:0] exp_q[$];
  logic [63:0] stream_pc = RESET_PC;
  logic        cap_stall_id = 1'b0;
  logic        cap_flush = 1'b0;
  logic        cap_rst_n = 1'b0;

  fetch_unit #(.DATA_SIZE(DATA_SIZE), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .flush_id        (flush_id),
    .redirect        (redirect),
    .new_pc          (new_pc),
    .inst_mem_en     (inst_mem_en),
    .inst_mem_addr   (inst_mem_addr),
    .inst_mem_ack    (inst_mem_ack),
    .inst_mem_rd_dat (inst_mem_rd_dat),
    .inst_id         (inst_id),
    .pc_id           (pc_id),
    .valid_id        (valid_id)
  );

  always #5 clk = ~clk;

  // Contents of instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[31:0] ^ a[63:32];
    return {w[15:0], w[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of hazard inputs and memory response, then step past the edge.
  task automatic applyStimulus(input logic si, input logic sid, input logic fl,
                               input logic rd, input logic [63:0] npc,
                               input logic ack_req);
    stall_if        = si;
    stall_id        = sid;
    flush_id        = fl;
    redirect        = rd;
    new_pc          = npc;
    inst_mem_ack    = ack_req & inst_mem_en;
    inst_mem_rd_dat = inst_mem_ack ? mem_word(inst_mem_addr) : $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 64'h0, 0);
    applyStimulus(0, 0, 0, 0, 64'h0, 0);
    rst_n = 1'b1;
  endtask

  // Stimulus-side model: record the hazards applied at the coming edge and keep
  // the expected program-order stream topped up, restarting it on reset/redirect.
  always @(negedge clk) begin
    cap_stall_id = stall_id;
    cap_flush    = flush_id;
    cap_rst_n    = rst_n;
    if (!rst_n) begin
      exp_q.delete();
      stream_pc = RESET_PC;
    end else if (redirect) begin
      exp_q.delete();
      stream_pc = new_pc;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(stream_pc);
      stream_pc = stream_pc + 64'd4;
    end
  end

  // Monitor: every instruction newly loaded into IF/ID must be the next one in
  // program order; flushed or empty slots must read as a NOP bubble.
  always begin
    logic [63:0] exp_pc;
    @(posedge clk);
    #1;
    if (rst_n && cap_rst_n) begin
      if (cap_flush) begin
        checkOutput("flush_valid", {63'b0, valid_id}, 64'd0);
        checkOutput("flush_inst", {32'b0, inst_id}, {32'b0, NOP});
      end else if (!cap_stall_id) begin
        if (valid_id) begin
          deliveries++;
          idle_cycles = 0;
          if (exp_q.size() == 0) begin
            checkOutput("sb_queue_empty", pc_id, 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            exp_pc = exp_q.pop_front();
            checkOutput("sb_pc", pc_id, exp_pc);
            checkOutput("sb_inst", {32'b0, inst_id}, {32'b0, mem_word(exp_pc)});
          end
        end else begin
          checkOutput("bubble_inst", {32'b0, inst_id}, {32'b0, NOP});
        end
      end
      idle_cycles++;
      if (idle_cycles > 200) begin
        checkOutput("watchdog_no_progress", 64'(idle_cycles), 64'd0);
        idle_cycles = 0;
      end
    end else begin
      idle_cycles = 0;
    end
  end

  initial begin
    logic [63:0] npc;
    logic        rd;
    rst_n = 1'b0;
    stall_if = 0; stall_id = 0; flush_id = 0; redirect = 0;
    new_pc = '0; inst_mem_ack = 0; inst_mem_rd_dat = '0;

    // Reset values, then zero-latency streaming with no hazards.
    repeat (3) applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("rst_en", {63'b0, inst_mem_en}, 64'd0);
    checkOutput("rst_addr", inst_mem_addr, RESET_PC);
    checkOutput("rst_inst", {32'b0, inst_id}, {32'b0, NOP});
    checkOutput("rst_pc_id", pc_id, 64'd0);
    checkOutput("rst_valid", {63'b0, valid_id}, 64'd0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("boot_en", {63'b0, inst_mem_en}, 64'd1);
    checkOutput("boot_valid", {63'b0, valid_id}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stream_addr", inst_mem_addr, 64'(4 * i));
      applyStimulus(0, 0, 0, 0, 64'h0, 1);
      checkOutput("stream_pc_id", pc_id, 64'(4 * i));
      checkOutput("stream_valid", {63'b0, valid_id}, 64'd1);
    end

    // Ack of 0x8 while decode is stalled for three cycles.
    doReset();
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("hold_pre_addr", inst_mem_addr, 64'h8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 64'h0, 1);
      checkOutput("hold_en", {63'b0, inst_mem_en}, 64'd0);
      checkOutput("hold_pc_id", pc_id, 64'h4);
      checkOutput("hold_valid", {63'b0, valid_id}, 64'd1);
    end
    applyStimulus(0, 0, 0, 0, 64'h0, 0);
    checkOutput("unhold_pc_id", pc_id, 64'h8);
    checkOutput("unhold_inst", {32'b0, inst_id}, {32'b0, mem_word(64'h8)});
    checkOutput("unhold_addr", inst_mem_addr, 64'hC);
    checkOutput("unhold_en", {63'b0, inst_mem_en}, 64'd1);

    // Redirect to 0x100 while 0x10 is outstanding.
    doReset();
    applyStimulus(0, 0, 0, 0, 64'h0, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("disc_pre_addr", inst_mem_addr, 64'h10);
    applyStimulus(0, 0, 1, 1, 64'h100, 0);
    checkOutput("disc_en", {63'b0, inst_mem_en}, 64'd1);
    checkOutput("disc_addr_held", inst_mem_addr, 64'h10);
    applyStimulus(0, 0, 0, 0, 64'h0, 0);
    checkOutput("disc_wait_addr", inst_mem_addr, 64'h10);
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("disc_new_addr", inst_mem_addr, 64'h100);
    checkOutput("disc_dropped", {63'b0, valid_id}, 64'd0);
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("disc_target_pc", pc_id, 64'h100);

    // Two redirects before the stale ack: the later target wins.
    doReset();
    applyStimulus(0, 0, 0, 0, 64'h0, 0);
    applyStimulus(0, 0, 1, 1, 64'h100, 0);
    applyStimulus(0, 0, 1, 1, 64'h200, 0);
    checkOutput("dbl_addr_held", inst_mem_addr, 64'h0);
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("dbl_new_addr", inst_mem_addr, 64'h200);
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("dbl_pc_id", pc_id, 64'h200);

    // Flush together with stall_id and an ack.
    doReset();
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    applyStimulus(0, 1, 1, 0, 64'h0, 1);
    checkOutput("fs_valid", {63'b0, valid_id}, 64'd0);
    checkOutput("fs_inst", {32'b0, inst_id}, {32'b0, NOP});
    checkOutput("fs_pc_id", pc_id, 64'h0);
    applyStimulus(0, 0, 0, 0, 64'h0, 0);
    checkOutput("fs_release_pc", pc_id, 64'h4);

    // Asynchronous reset in the middle of a request at 0x40.
    doReset();
    applyStimulus(0, 0, 0, 0, 64'h0, 0);
    applyStimulus(0, 0, 1, 1, 64'h3C, 1);
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    applyStimulus(0, 1, 0, 0, 64'h0, 0);
    checkOutput("mid_addr", inst_mem_addr, 64'h40);
    checkOutput("mid_pc_id", pc_id, 64'h3C);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_en", {63'b0, inst_mem_en}, 64'd0);
    checkOutput("async_addr", inst_mem_addr, RESET_PC);
    checkOutput("async_pc_id", pc_id, 64'd0);
    checkOutput("async_valid", {63'b0, valid_id}, 64'd0);
    checkOutput("async_inst", {32'b0, inst_id}, {32'b0, NOP});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("restart_addr", inst_mem_addr, RESET_PC);
    checkOutput("restart_en", {63'b0, inst_mem_en}, 64'd1);
    applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checkOutput("restart_pc_id", pc_id, RESET_PC);

    // Randomized traffic: hazards, redirects with flush, variable memory latency.
    doReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) doReset();
      rd  = ($urandom_range(0, 99) < 8);
      npc = {$urandom, $urandom};
      npc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) npc = 64'hFFFF_FFFF_FFFF_FFF4;
      applyStimulus($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2, rd, rd,
                    npc, $urandom_range(0, 9) < 6);
    end
    repeat (4) applyStimulus(0, 0, 0, 0, 64'h0, 1);
    checks++;
    if (deliveries < 300) begin
      errors++;
      $display("[TB] FAIL total_deliveries: got %0d, expected at least 300", deliveries);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
